regbank_op_arbiter: RTL and testbench

- Shares one write/operate path into a bank of n_bitRegister instances among several requesters.
- Each cycle, picks one pending request by round-robin and drives the target register's E, FunSel and I for one cycle.
- Supports locked (atomic) multi-op sequences by one requester.
- Sits between the control units/microsequencers and the register bank.

---
 rtl/regbank_op_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regbank_op_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_op_arbiter.sv
// Round-robin arbiter sharing one E/FunSel/I write path into a register bank, with locked
// multi-op sequences. Optional lock timeout and LockErr pulse under macro LOCK_TIMEOUT_EN.
module regbank_op_arbiter #(
   parameter int  N        = 8,
   parameter int  NREQ     = 4,
   parameter int  NREG     = 4,
   parameter int  LOCK_MAX = 16,
   localparam int SELW     = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NREQ-1:0]      Req,
   input  logic [NREQ-1:0]      ReqLock,
   input  logic [2*NREQ-1:0]    ReqFunSel,
   input  logic [SELW*NREQ-1:0] ReqSel,
   input  logic [N*NREQ-1:0]    ReqData,
   output logic [NREQ-1:0]      Gnt,
   output logic [NREG-1:0]      RegE,
   output logic [1:0]           RegFunSel,
   output logic [N-1:0]         RegI,
   output logic                 Busy,
   output logic                 LockErr
);
   localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   if (LOCK_MAX < 1) begin : g_lock_max_chk
      $error("regbank_op_arbiter: LOCK_MAX must be at least 1");
   end

   state_e          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREG-1:0] rege_q;
   logic [1:0]      funsel_q;
   logic [N-1:0]    regi_q;
   logic            lockerr_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   own_q;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] gnt_s;
   logic [NREG-1:0] rege_s;
   logic            win_vld_s;
   logic [PW-1:0]   win_idx_s;
   logic [PW-1:0]   src_s;
   logic            hold_s;
   logic            tmo_s;
   logic            lock_s;
   logic            op_s;
   logic            sel_ok_s;
   logic [SELW-1:0] sel_s;
   logic [1:0]      fs_s;
   logic [N-1:0]    data_s;

`ifdef LOCK_TIMEOUT_EN
   localparam int            CW      = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] inhib_q;

   // Timeout fires only while the owner still asks to keep the lock.
   always_comb begin
      tmo_s  = (state_q == LOCKED) && ReqLock[own_q] && (cnt_q >= CNT_MAX);
      lock_s = ReqLock[win_idx_s] && !inhib_q[win_idx_s];
   end

   // Lock-cycle counter; a forcibly released owner may not relock until its ReqLock drops.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         inhib_q <= '0;
      end else begin
         if (hold_s) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (win_vld_s) begin
            cnt_q <= CW'(1);
         end else begin
            cnt_q <= cnt_q;
         end
         inhib_q <= (inhib_q & ReqLock) | (tmo_s ? gnt_q : '0);
      end
   end
`else
   // Locks are unbounded in this build.
   always_comb begin
      tmo_s  = 1'b0;
      lock_s = ReqLock[win_idx_s];
   end
`endif

   // Winner scan: first eligible requester at or after ptr_q, wrapping; last grantee masked.
   always_comb begin
      elig_s    = Req & ~gnt_q;
      win_vld_s = 1'b0;
      win_idx_s = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (elig_s[(int'(ptr_q) + i) % NREQ]) begin
            win_vld_s = 1'b1;
            win_idx_s = PW'((int'(ptr_q) + i) % NREQ);
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Select the lane that drives the bank next cycle: the lock owner or a fresh winner.
   always_comb begin
      hold_s   = (state_q == LOCKED) && ReqLock[own_q] && !tmo_s;
      src_s    = hold_s ? own_q : win_idx_s;
      op_s     = hold_s ? Req[own_q] : win_vld_s;
      sel_s    = ReqSel[SELW*src_s +: SELW];
      fs_s     = ReqFunSel[2*src_s +: 2];
      data_s   = ReqData[N*src_s +: N];
      sel_ok_s = (int'(sel_s) < NREG);
      for (int k = 0; k < NREQ; k++) begin
         gnt_s[k] = (int'(src_s) == k);
      end
      for (int r = 0; r < NREG; r++) begin
         rege_s[r] = op_s && (int'(sel_s) == r);
      end
   end

   // Arbitration FSM; every bank-facing output is registered here.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         rege_q    <= '0;
         funsel_q  <= 2'b00;
         regi_q    <= '0;
         lockerr_q <= 1'b0;
         ptr_q     <= '0;
         own_q     <= '0;
      end else begin
         lockerr_q <= tmo_s;
         if (hold_s || win_vld_s) begin
            gnt_q  <= gnt_s;
            rege_q <= rege_s;
            if (op_s && sel_ok_s) begin
               funsel_q <= fs_s;
               regi_q   <= data_s;
            end
         end else begin
            gnt_q  <= '0;
            rege_q <= '0;
         end
         case (state_q)
            IDLE, ISSUE, LOCKED: begin
               if (hold_s) begin
                  state_q <= LOCKED;
               end else if (win_vld_s) begin
                  ptr_q   <= (win_idx_s == PTR_LAST) ? '0 : win_idx_s + PW'(1);
                  own_q   <= win_idx_s;
                  state_q <= lock_s ? LOCKED : ISSUE;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Gnt       = gnt_q;
   assign RegE      = rege_q;
   assign RegFunSel = funsel_q;
   assign RegI      = regi_q;
   assign Busy      = |gnt_q;
   assign LockErr   = lockerr_q;

endmodule

// File: tb/tb_regbank_op_arbiter.sv
// Bench for regbank_op_arbiter: directed vectors, a cycle model checked every negedge,
// and hand-computed literal expectations pinning that model.
module tb_regbank_op_arbiter;
   localparam int NREQ = 4;
   localparam int NREG = 4;
   localparam int LM   = 4;
`ifdef LOCK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic [3:0]      req;
   logic [3:0]      req_lock;
   logic [1:0]      req_fs   [4];
   logic [1:0]      req_sel  [4];
   logic [7:0]      req_data [4];
   logic [7:0]      fs_bus;
   logic [7:0]      sel_bus;
   logic [31:0]     data_bus;
   logic [3:0]      Gnt;
   logic [3:0]      RegE;
   logic [1:0]      RegFunSel;
   logic [7:0]      RegI;
   logic            Busy;
   logic            LockErr;

   int checks = 0;
   int errors = 0;

   // model state: pointer, current grantee, lock owner, lock age, relock inhibit
   int         m_ptr, m_last, m_own, m_cnt;
   bit         m_locked;
   bit         m_inh [4];
   logic [3:0] m_gnt;
   logic [3:0] m_rege;
   logic [1:0] m_fs;
   logic [7:0] m_i;
   logic       m_err;

   assign fs_bus   = {req_fs[3], req_fs[2], req_fs[1], req_fs[0]};
   assign sel_bus  = {req_sel[3], req_sel[2], req_sel[1], req_sel[0]};
   assign data_bus = {req_data[3], req_data[2], req_data[1], req_data[0]};

   regbank_op_arbiter #(.N(8), .NREQ(NREQ), .NREG(NREG), .LOCK_MAX(LM)) dut (
      .CLK(clk), .RST_N(rst_n), .Req(req), .ReqLock(req_lock),
      .ReqFunSel(fs_bus), .ReqSel(sel_bus), .ReqData(data_bus),
      .Gnt(Gnt), .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI),
      .Busy(Busy), .LockErr(LockErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_ptr = 0; m_last = -1; m_own = 0; m_cnt = 0; m_locked = 1'b0;
      for (int i = 0; i < 4; i++) m_inh[i] = 1'b0;
      m_gnt = 4'b0000; m_rege = 4'b0000; m_fs = 2'b00; m_i = 8'h00; m_err = 1'b0;
   endtask

   task automatic m_op(input int w);
      int s;
      s = int'(req_sel[w]);
      m_rege = 4'b0000;
      if (s < NREG) begin
         m_rege[s] = 1'b1;
         m_fs = req_fs[w];
         m_i  = req_data[w];
      end
   endtask

   // Predict outputs after the coming rising edge from the inputs now applied.
   task automatic m_step();
      int  w, prev_own;
      bit  forced, hold;
      forced = 1'b0; hold = 1'b0; prev_own = m_own;
      if (m_locked && req_lock[m_own]) begin
         if (TMO_EN && m_cnt >= LM) forced = 1'b1;
         else hold = 1'b1;
      end
      m_err = forced;
      if (hold) begin
         m_cnt++;
         if (req[m_own]) m_op(m_own);
         else m_rege = 4'b0000;
      end else begin
         m_locked = 1'b0;
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (w < 0 && req[c] && c != m_last) w = c;
         end
         if (w < 0) begin
            m_gnt = 4'b0000; m_rege = 4'b0000; m_last = -1;
         end else begin
            m_gnt = 4'b0000; m_gnt[w] = 1'b1;
            m_op(w);
            m_ptr  = (w + 1) % NREQ;
            m_last = w;
            if (req_lock[w] && !m_inh[w]) begin
               m_locked = 1'b1; m_own = w; m_cnt = 1;
            end
         end
      end
      for (int i = 0; i < 4; i++) if (!req_lock[i]) m_inh[i] = 1'b0;
      if (forced) m_inh[prev_own] = 1'b1;
   endtask

   // Compare DUT against the model every falling edge, then advance the model.
   initial begin
      m_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) m_reset();
         chk("m_gnt",    32'(Gnt),       32'(m_gnt));
         chk("m_rege",   32'(RegE),      32'(m_rege));
         chk("m_funsel", 32'(RegFunSel), 32'(m_fs));
         chk("m_regi",   32'(RegI),      32'(m_i));
         chk("m_busy",   32'(Busy),      32'(|m_gnt));
         chk("m_lockerr",32'(LockErr),   32'(m_err));
         if (rst_n) m_step();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] rr_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
   logic [9:0] exp_g;
   logic [9:0] exp_e;

   initial begin
      rst_n = 1'b0; req = 4'b0000; req_lock = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         req_fs[i] = 2'b00; req_sel[i] = 2'b00; req_data[i] = 8'h00;
      end
      step(); step();
      chk("reset_gnt", 32'(Gnt), 32'h0);
      chk("reset_regi", 32'(RegI), 32'h0);
      rst_n = 1'b1;

      // single op from requester 2
      req_sel[2] = 2'd3; req_fs[2] = 2'b01; req_data[2] = 8'hAA; req = 4'b0100;
      step();
      chk("single_gnt", 32'(Gnt), 32'h4);
      chk("single_rege", 32'(RegE), 32'h8);
      chk("single_fs", 32'(RegFunSel), 32'h1);
      chk("single_regi", 32'(RegI), 32'hAA);
      req = 4'b0000;
      step();
      chk("single_gnt_drop", 32'(Gnt), 32'h0);
      chk("single_rege_drop", 32'(RegE), 32'h0);
      chk("single_regi_hold", 32'(RegI), 32'hAA);

      // round robin from a fresh pointer
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_sel[i] = 2'(i); req_fs[i] = 2'(i); req_data[i] = 8'h10 + 8'(i);
      end
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("rr_gnt", 32'(Gnt), 32'(rr_g[c]));
         chk("rr_regi", 32'(RegI), 32'(rr_d[c]));
      end
      req = 4'b0000;
      step();

      // locked three-op sequence by requester 1 while everyone requests
      req_sel[1] = 2'd0; req_fs[1] = 2'b10; req_data[1] = 8'h01;
      req = 4'b1111; req_lock = 4'b0010;
      step();
      chk("lock_gnt1", 32'(Gnt), 32'h2);
      chk("lock_rege1", 32'(RegE), 32'h1);
      chk("lock_regi1", 32'(RegI), 32'h01);
      req_data[1] = 8'h02;
      step();
      chk("lock_gnt2", 32'(Gnt), 32'h2);
      chk("lock_regi2", 32'(RegI), 32'h02);
      req_data[1] = 8'h03;
      step();
      chk("lock_gnt3", 32'(Gnt), 32'h2);
      chk("lock_regi3", 32'(RegI), 32'h03);
      req_lock = 4'b0000;
      step();
      chk("lock_release_gnt", 32'(Gnt), 32'h4);
      chk("lock_release_regi", 32'(RegI), 32'h12);
      req = 4'b0000;
      step();

      // lock bubble by requester 3
      req_data[3] = 8'h33; req = 4'b1000; req_lock = 4'b1000;
      step();
      chk("bubble_gnt0", 32'(Gnt), 32'h8);
      chk("bubble_regi0", 32'(RegI), 32'h33);
      req = 4'b0000;
      step();
      chk("bubble_gnt", 32'(Gnt), 32'h8);
      chk("bubble_rege", 32'(RegE), 32'h0);
      chk("bubble_regi", 32'(RegI), 32'h33);
      req = 4'b1000; req_data[3] = 8'h44;
      step();
      chk("bubble_after_rege", 32'(RegE), 32'h8);
      chk("bubble_after_regi", 32'(RegI), 32'h44);
      req = 4'b0000; req_lock = 4'b0000;
      step();
      chk("bubble_release", 32'(Gnt), 32'h0);

      // asynchronous reset in the middle of a lock
      req_sel[0] = 2'd2; req_fs[0] = 2'b11; req_data[0] = 8'h5A;
      req = 4'b0001; req_lock = 4'b0001;
      step();
      chk("rstlock_gnt", 32'(Gnt), 32'h1);
      chk("rstlock_rege", 32'(RegE), 32'h4);
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt", 32'(Gnt), 32'h0);
      chk("async_rege", 32'(RegE), 32'h0);
      chk("async_fs", 32'(RegFunSel), 32'h0);
      chk("async_regi", 32'(RegI), 32'h0);
      chk("async_busy", 32'(Busy), 32'h0);
      req = 4'b0000; req_lock = 4'b0000;
      step();
      rst_n = 1'b1;
      req = 4'b1001;
      step();
      chk("ptr_after_reset", 32'(Gnt), 32'h1);
      req = 4'b0000;
      step();

      // requester 0 holds ReqLock for ten cycles
      req = 4'b0001; req_lock = 4'b0001;
      if (TMO_EN) begin
         exp_g = 10'b1010101111;
         exp_e = 10'b0000010000;
      end else begin
         exp_g = 10'b1111111111;
         exp_e = 10'b0000000000;
      end
      for (int c = 0; c < 10; c++) begin
         step();
         chk("long_lock_gnt", 32'(Gnt[0]), 32'(exp_g[c]));
         chk("long_lock_err", 32'(LockErr), 32'(exp_e[c]));
      end
      req = 4'b0000; req_lock = 4'b0000;
      step();
      req = 4'b0001; req_lock = 4'b0001;
      step();
      chk("relock_gnt0", 32'(Gnt), 32'h1);
      step();
      chk("relock_gnt1", 32'(Gnt), 32'h1);
      req = 4'b0000; req_lock = 4'b0000;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
